// File: rtl/regfile_debug_scanner_pkg.sv
// Shared widths and scan FSM state encoding for the register file debug scanner.
package regfile_debug_scanner_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    SETTLE = 3'd3,
    SEND   = 3'd4
  } scan_state_t;

endpackage

// File: rtl/regfile_debug_scanner.sv
// Walks a register address range over the register file debug port and streams
// each captured word, tagged with its address, on a valid/ready interface.
module regfile_debug_scanner
  import regfile_debug_scanner_pkg::*;
#(
  parameter int unsigned ADDR_W        = REG_ADDR_W,
  parameter int unsigned DATA_W        = REG_DATA_W,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] read_address_debug,
  output logic              clock_debug,
  input  logic [DATA_W-1:0] data_output_debug,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  scan_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur, w_cur_nxt;
  logic [ADDR_W-1:0] r_last, w_last_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_clk_dbg, w_clk_dbg_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [ADDR_W-1:0] r_out_addr, w_out_addr_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [ADDR_W-1:0] w_cur_inc;

  assign w_cur_inc = ADDR_W'(r_cur + 1'b1);

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_clk_dbg   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_clk_dbg   <= w_clk_dbg_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next state and next output values; strobe and done are single-cycle by default
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_rd_addr_nxt   = r_rd_addr;
    w_clk_dbg_nxt   = 1'b0;
    w_out_valid_nxt = r_out_valid;
    w_out_addr_nxt  = r_out_addr;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;

    if (abort) begin
      // Abort also masks a simultaneous start in IDLE; the pending beat is dropped
      w_state_nxt     = IDLE;
      w_out_valid_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_cur_nxt     = first_addr;
            w_last_nxt    = last_addr;
            w_rd_addr_nxt = first_addr;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = SETUP;
          end
        end
        SETUP: begin
          w_clk_dbg_nxt = 1'b1;
          w_state_nxt   = STROBE;
        end
        STROBE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = SETTLE;
        end
        SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            w_out_data_nxt  = data_output_debug;
            w_out_addr_nxt  = r_cur;
            w_out_last_nxt  = (r_cur == r_last);
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = SEND;
          end else begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          end
        end
        SEND: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
            if (r_out_last) begin
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_cur_nxt     = w_cur_inc;
              w_rd_addr_nxt = w_cur_inc;
              w_state_nxt   = SETUP;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign read_address_debug = r_rd_addr;
  assign clock_debug        = r_clk_dbg;
  assign out_valid          = r_out_valid;
  assign out_addr           = r_out_addr;
  assign out_data           = r_out_data;
  assign out_last           = r_out_last;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_regfile_debug_scanner.sv
// Scoreboard bench for regfile_debug_scanner against a register file at power-on values (xN = N).
module tb_regfile_debug_scanner;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  read_address_debug;
  logic        clock_debug;
  logic [31:0] data_output_debug;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    beats = 0;
  int    done_cnt = 0;
  int    last_hs = -1;
  bit    gap_chk = 1'b0;
  logic  prev_cd = 1'b0;
  logic  prev_done = 1'b0;

  regfile_debug_scanner dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .first_addr         (first_addr),
    .last_addr          (last_addr),
    .read_address_debug (read_address_debug),
    .clock_debug        (clock_debug),
    .data_output_debug  (data_output_debug),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_addr           (out_addr),
    .out_data           (out_data),
    .out_last           (out_last),
    .busy               (busy),
    .done               (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file debug port: xN holds N, sampled on the strobe's rising edge
  always @(posedge clock_debug) data_output_debug <= 32'(read_address_debug);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(out_addr), 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_addr", 32'(out_addr), 32'(e.a));
        chk("beat_data", out_data, e.d);
        chk("beat_last", 32'(out_last), 32'(e.l));
        beats++;
        if (gap_chk && last_hs >= 0) chk("beat_gap", 32'(cyc - last_hs), 32'd4);
        last_hs = cyc;
      end
    end
    if (clock_debug) chk("clkdbg_one_cycle", 32'(prev_cd), 32'd0);
    if (done) begin
      chk("done_one_cycle", 32'(prev_done), 32'd0);
      done_cnt++;
    end
    prev_cd   = clock_debug;
    prev_done = done;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_range(input logic [4:0] f, input logic [4:0] l, input int max_n);
    logic [4:0] a;
    a = f;
    for (int i = 0; i < max_n; i++) begin
      exp_q.push_back('{a: a, d: 32'(a), l: (a == l)});
      if (a == l) break;
      a = 5'(a + 5'd1);
    end
  endtask

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Drops out_ready the cycle the beat for addr appears
  task automatic stall_on(input logic [4:0] addr, input int budget);
    int n;
    n = 0;
    while (!(out_valid && out_addr == addr) && n < budget) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("stall_reached", 32'(out_valid && out_addr == addr), 32'd1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_rd_addr", 32'(read_address_debug), 32'd0);
    chk("rst_clkdbg", 32'(clock_debug), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    // Full dump 0..31 at minimum latency
    push_range(5'd0, 5'd31, 32);
    beats = 0; d0 = done_cnt; gap_chk = 1'b1; last_hs = -1;
    do_start(5'd0, 5'd31);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("setup_addr", 32'(read_address_debug), 32'd0);
    wait_idle(200);
    step();
    gap_chk = 1'b0;
    chk("full_beats", 32'(beats), 32'd32);
    chk("full_done", 32'(done_cnt - d0), 32'd1);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Wrapping range 30..1
    push_range(5'd30, 5'd1, 32);
    beats = 0;
    do_start(5'd30, 5'd1);
    wait_idle(100);
    step();
    chk("wrap_beats", 32'(beats), 32'd4);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on x5
    push_range(5'd0, 5'd31, 32);
    beats = 0;
    do_start(5'd0, 5'd31);
    stall_on(5'd5, 60);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_addr", 32'(out_addr), 32'd5);
      chk("stall_data", out_data, 32'd5);
      chk("stall_clkdbg", 32'(clock_debug), 32'd0);
      chk("stall_rd_addr", 32'(read_address_debug), 32'd5);
    end
    out_ready = 1'b1;
    step();
    chk("resume_rd_addr", 32'(read_address_debug), 32'd6);
    chk("resume_setup_clk", 32'(clock_debug), 32'd0);
    step();
    chk("resume_strobe", 32'(clock_debug), 32'd1);
    wait_idle(200);
    step();
    chk("bp_beats", 32'(beats), 32'd32);

    // Start while busy is ignored
    push_range(5'd0, 5'd31, 32);
    beats = 0;
    do_start(5'd0, 5'd31);
    repeat (10) step();
    do_start(5'd7, 5'd7);
    wait_idle(200);
    step();
    chk("ign_beats", 32'(beats), 32'd32);
    chk("ign_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort wins over start in IDLE
    first_addr = 5'd2; last_addr = 5'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);

    // Abort while holding the beat for x10
    push_range(5'd0, 5'd31, 10);
    beats = 0; d0 = done_cnt;
    do_start(5'd0, 5'd31);
    stall_on(5'd10, 60);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_clkdbg", 32'(clock_debug), 32'd0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_beats", 32'(beats), 32'd10);
    push_range(5'd3, 5'd3, 32);
    beats = 0;
    do_start(5'd3, 5'd3);
    wait_idle(40);
    step();
    chk("single_beats", 32'(beats), 32'd1);
    chk("single_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during STROBE of the first register
    do_start(5'd0, 5'd31);
    begin
      int n;
      n = 0;
      while (!clock_debug && n < 10) begin
        step();
        n++;
      end
    end
    chk("rst_mid_strobe_seen", 32'(clock_debug), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstm_clkdbg", 32'(clock_debug), 32'd0);
    chk("rstm_rd_addr", 32'(read_address_debug), 32'd0);
    chk("rstm_valid", 32'(out_valid), 32'd0);
    chk("rstm_out_addr", 32'(out_addr), 32'd0);
    chk("rstm_out_data", out_data, 32'd0);
    chk("rstm_last", 32'(out_last), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_done", 32'(done), 32'd0);
    repeat (5) step();
    chk("rstm_stay_busy", 32'(busy), 32'd0);
    chk("rstm_stay_clkdbg", 32'(clock_debug), 32'd0);
    chk("rstm_stay_rd_addr", 32'(read_address_debug), 32'd0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
